// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory bus.
//   Port 0 is the pipeline LSU, port 1 the UART loader. A granted request is
//   latched onto the bus and held until bus_ready or a timeout abort, then
//   the owner gets a one-cycle ack carrying rdata/err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/addr/wdata/wmask  requester fields (held until ack)
//   pN_ack/err/rdata         registered completion, one cycle
//   stall                    p0_req & ~p0_ack, pipeline hold
//   bus_valid/we/addr/wdata/wmask  registered downstream transaction
//   bus_ready/bus_rdata      downstream completion and read data
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's fields
// BUSY  | bus_valid high, waiting for bus_ready or timeout
// DONE  | owner's ack pulse visible this cycle
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        stall,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          grant1;
  logic          busy_done;
  logic          busy_err;
  logic [31:0]   done_rdata;

  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  assign grant1 = p1_req & (~p0_req | ~last_grant);

  assign stall = p0_req & ~p0_ack;

  // bus_ready has priority over the timeout on the same cycle.
  assign busy_done  = bus_ready | (cnt == CW'(TIMEOUT - 1));
  assign busy_err   = ~bus_ready;
  assign done_rdata = (bus_ready & ~bus_we) ? bus_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      bus_wmask  <= 4'h0;
      p0_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p0_rdata   <= 32'h0;
      p1_ack     <= 1'b0;
      p1_err     <= 1'b0;
      p1_rdata   <= 32'h0;
    end else begin
      // Ack/err/rdata are single-cycle pulses; zero unless set below.
      p0_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= 32'h0;
      p1_ack   <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (p0_req | p1_req) begin
            owner      <= grant1;
            last_grant <= grant1;
            bus_we     <= grant1 ? p1_we    : p0_we;
            bus_addr   <= grant1 ? p1_addr  : p0_addr;
            bus_wdata  <= grant1 ? p1_wdata : p0_wdata;
            bus_wmask  <= grant1 ? p1_wmask : p0_wmask;
            bus_valid  <= 1'b1;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (busy_done) begin
            bus_valid <= 1'b0;
            cnt       <= '0;
            state     <= DONE;
            if (owner) begin
              p1_ack   <= 1'b1;
              p1_err   <= busy_err;
              p1_rdata <= done_rdata;
            end else begin
              p0_ack   <= 1'b1;
              p0_err   <= busy_err;
              p0_rdata <= done_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard: stimulus pushes the
// expected ack (port, err, rdata); a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        stall, bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .stall(stall), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
      n_cmp++;
      if (p0_ack && p1_ack) begin
        n_bad++;
        $display("FAIL dual_ack: got both acks expected one");
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack: got ack p0=%0b p1=%0b expected none", p0_ack, p1_ack);
      end else begin
        exp_t e;
        logic        a_err;
        logic [31:0] a_rd;
        e = exp_q.pop_front();
        a_err = p1_ack ? p1_err : p0_err;
        a_rd  = p1_ack ? p1_rdata : p0_rdata;
        if (p1_ack !== e.port || a_err !== e.err || a_rd !== e.rdata) begin
          n_bad++;
          $display("FAIL ack_resp: got port=%0b err=%0b rdata=0x%08h expected port=%0b err=%0b rdata=0x%08h",
                   p1_ack, a_err, a_rd, e.port, e.err, e.rdata);
        end
      end
    end else begin
      n_cmp++;
      if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_zero: got rdata0=0x%08h rdata1=0x%08h err0=%0b err1=%0b expected zeros",
                 p0_rdata, p1_rdata, p0_err, p1_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic err, input logic [31:0] rd);
    exp_t e;
    e.port = port;
    e.err = err;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (bus_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("bus_valid_seen", {31'h0, bus_valid}, 32'h1);
  endtask

  // Hold bus_ready low for 'delay' BUSY cycles, then complete with rd.
  task automatic serve(input int delay, input logic [31:0] rd, input logic [31:0] exp_addr);
    wait_valid();
    for (int i = 0; i < delay; i++) begin
      chk("bus_addr_hold", bus_addr, exp_addr);
      tick();
    end
    chk("bus_valid_busy", {31'h0, bus_valid}, 32'h1);
    chk("bus_addr", bus_addr, exp_addr);
    bus_ready = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
  endtask

  // Wait for an ack, then the acked requester drops its request.
  task automatic wait_ack();
    int k = 0;
    while (!(p0_ack | p1_ack) && k < 40) begin
      tick();
      k++;
    end
    chk("ack_seen", {31'h0, p0_ack | p1_ack}, 32'h1);
    chk("bus_valid_done", {31'h0, bus_valid}, 32'h0);
    if (p0_ack) p0_req = 1'b0;
    if (p1_ack) p1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wmask = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wmask = 0;
    bus_ready = 0; bus_rdata = 0;
    tick();
    tick();
    chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_acks", {30'h0, p0_ack, p1_ack}, 32'h0);
    p0_req = 1'b1;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h1);

    // Minimum-latency p0 read.
    tick();
    rst = 1'b0;
    p0_addr = 32'h0000_0010;
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    #1;
    chk("c0_stall", {31'h0, stall}, 32'h1);
    tick();
    chk("c1_bus_valid", {31'h0, bus_valid}, 32'h1);
    chk("c1_bus_addr", bus_addr, 32'h0000_0010);
    chk("c1_stall", {31'h0, stall}, 32'h1);
    bus_ready = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    chk("c2_p0_ack", {31'h0, p0_ack}, 32'h1);
    chk("c2_stall", {31'h0, stall}, 32'h0);
    p0_req = 1'b0;
    tick();
    chk("c3_p0_ack", {31'h0, p0_ack}, 32'h0);

    // Tie after reset: p0, p1, then p0, p1 again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    p1_req = 1; p1_we = 0; p1_addr = 32'h80;
    push(1'b0, 1'b0, 32'h0000_0011);
    push(1'b1, 1'b0, 32'h0000_0022);
    serve(0, 32'h0000_0011, 32'h40);
    wait_ack();
    serve(0, 32'h0000_0022, 32'h80);
    wait_ack();
    tick();
    p0_req = 1; p1_req = 1;
    push(1'b0, 1'b0, 32'h0000_0033);
    push(1'b1, 1'b0, 32'h0000_0044);
    serve(2, 32'h0000_0033, 32'h40);
    wait_ack();
    serve(1, 32'h0000_0044, 32'h80);
    wait_ack();
    tick();

    // p1 write never answered: 16 BUSY cycles then err.
    p1_req = 1; p1_we = 1; p1_addr = 32'h100; p1_wdata = 32'h1234_5678; p1_wmask = 4'b0011;
    push(1'b1, 1'b1, 32'h0);
    wait_valid();
    chk("to_bus_we", {31'h0, bus_we}, 32'h1);
    chk("to_bus_wdata", bus_wdata, 32'h1234_5678);
    chk("to_bus_wmask", {28'h0, bus_wmask}, 32'h3);
    cnt = 0;
    while (bus_valid === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_busy_cycles", cnt, 32'd16);
    wait_ack();
    tick();

    // bus_ready on the 16th BUSY cycle beats the timeout.
    p0_req = 1; p0_we = 0; p0_addr = 32'h200;
    push(1'b0, 1'b0, 32'hCAFE_F00D);
    serve(15, 32'hCAFE_F00D, 32'h200);
    wait_ack();
    tick();

    // Requester drops req mid-transaction; ack still delivered.
    p1_req = 1; p1_we = 0; p1_addr = 32'h300;
    push(1'b1, 1'b0, 32'hA5A5_0001);
    wait_valid();
    p1_req = 1'b0;
    serve(2, 32'hA5A5_0001, 32'h300);
    wait_ack();
    tick();

    // bus_ready while idle is ignored.
    bus_ready = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    tick();
    tick();
    chk("idle_ready_acks", {30'h0, p0_ack, p1_ack}, 32'h0);
    chk("idle_ready_valid", {31'h0, bus_valid}, 32'h0);
    bus_ready = 1'b0;
    bus_rdata = 32'h0;

    // Field changes after grant do not reach the bus.
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    push(1'b0, 1'b0, 32'h0BAD_F00D);
    wait_valid();
    p0_addr = 32'h20;
    serve(3, 32'h0BAD_F00D, 32'h10);
    wait_ack();
    tick();

    // Reset mid-BUSY aborts silently; next tie goes to p0.
    p1_req = 1; p1_we = 1; p1_addr = 32'h400; p1_wdata = 32'hFFFF_0000; p1_wmask = 4'hF;
    wait_valid();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_busy_ack", {30'h0, p0_ack, p1_ack}, 32'h0);
    p0_req = 1; p0_we = 0; p0_addr = 32'h500;
    push(1'b0, 1'b0, 32'h7777_0000);
    push(1'b1, 1'b0, 32'h0);
    serve(1, 32'h7777_0000, 32'h500);
    wait_ack();
    serve(0, 32'hFFFF_FFFF, 32'h400);
    wait_ack();
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
